// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD digit-entry controller.
// State encoding plus the BCD digit width and largest legal digit value.
package bcd_pkg;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      FULL    = 2'd1,
      ERR     = 2'd2
   } state_e;

   localparam int         BCD_W   = 4;
   localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_check.sv
// Combinational BCD range check: flags a nibble that is a legal decimal digit.
// Zero latency; no flow control.
module bcd_digit_check
   import bcd_pkg::*;
(
   input  logic [BCD_W-1:0] digit,
   output logic             is_bcd
);

   assign is_bcd = (digit <= BCD_MAX);

endmodule

// File: rtl/bcd_entry_ctrl.sv
// Serial BCD digit entry: shifts in NDIGITS checked digits, presents the word on valid/ready.
// Word valid the cycle after the last digit; input stalls while FULL or ERR, clear has top priority.
module bcd_entry_ctrl
   import bcd_pkg::*;
#(
   parameter int NDIGITS = 4,
   parameter int CW      = $clog2(NDIGITS + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [BCD_W-1:0]       in_digit,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   clear,
   output logic [4*NDIGITS-1:0]   out_bcd,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   error,
   output logic [CW-1:0]          count
);

   state_e                 state_q, state_d;
   logic [4*NDIGITS-1:0]   bcd_q, bcd_d;
   logic [CW-1:0]          count_q, count_d;
   logic [4*NDIGITS-1:0]   shifted;
   logic [CW-1:0]          count_inc;
   logic                   is_bcd;

   bcd_digit_check u_digit_check (
      .digit  (in_digit),
      .is_bcd (is_bcd)
   );

   // The first digit entered ends up in the most significant nibble.
   if (NDIGITS > 1) begin : g_shift
      assign shifted = {bcd_q[4*NDIGITS-5:0], in_digit};
   end else begin : g_single
      assign shifted = in_digit;
   end

   assign count_inc = count_q + CW'(1);

   always_comb begin
      state_d = state_q;
      bcd_d   = bcd_q;
      count_d = count_q;
      if (clear) begin
         state_d = COLLECT;
         bcd_d   = '0;
         count_d = '0;
      end else begin
         case (state_q)
            COLLECT: begin
               if (in_valid) begin
                  if (is_bcd) begin
                     bcd_d   = shifted;
                     count_d = count_inc;
                     if (count_inc == CW'(NDIGITS)) begin
                        state_d = FULL;
                     end
                  end else begin
                     state_d = ERR;
                  end
               end
            end
            FULL: begin
               if (out_ready) begin
                  state_d = COLLECT;
                  bcd_d   = '0;
                  count_d = '0;
               end
            end
            ERR: begin
               state_d = ERR;
            end
            default: begin
               state_d = COLLECT;
               bcd_d   = '0;
               count_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= COLLECT;
         bcd_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         bcd_q   <= bcd_d;
         count_q <= count_d;
      end
   end

   assign in_ready  = (state_q == COLLECT);
   assign out_valid = (state_q == FULL);
   assign error     = (state_q == ERR);
   assign out_bcd   = bcd_q;
   assign count     = count_q;

endmodule

// File: tb/tb_bcd_entry_ctrl.sv
// Self-checking bench for bcd_entry_ctrl (NDIGITS=4): directed scenarios plus
// randomized traffic compared against a digit-queue reference model.
module tb_bcd_entry_ctrl;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  in_digit;
   logic        in_valid;
   logic        in_ready;
   logic        clear;
   logic [15:0] out_bcd;
   logic        out_valid;
   logic        out_ready;
   logic        error;
   logic [2:0]  count;

   int compared   = 0;
   int mismatched = 0;

   // Reference model: the digits held so far, plus the sticky error flag.
   int mq[$];
   bit merr;

   logic [21:0] obs;
   logic [21:0] exp_v;

   assign obs = {out_bcd, count, out_valid, in_ready, error};

   always #5 clk = ~clk;

   bcd_entry_ctrl #(.NDIGITS(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_digit  (in_digit),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .clear     (clear),
      .out_bcd   (out_bcd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .error     (error),
      .count     (count)
   );

   function automatic logic [21:0] pack(input logic [15:0] b, input logic [2:0] c,
                                        input logic ov, input logic ir, input logic er);
      return {b, c, ov, ir, er};
   endfunction

   function automatic logic [21:0] model_view();
      logic [15:0] b;
      b = 16'h0;
      foreach (mq[i]) b = (b << 4) + 16'(mq[i]);
      return pack(b, 3'(mq.size()), !merr && mq.size() == N, !merr && mq.size() < N, merr);
   endfunction

   // Apply one cycle of inputs, advance the model at the edge, settle for sampling.
   task automatic step(input logic v, input logic [3:0] d, input logic clr,
                       input logic ordy, input logic rst);
      in_valid  = v;
      in_digit  = d;
      clear     = clr;
      out_ready = ordy;
      reset     = rst;
      @(posedge clk);
      if (rst || clr) begin
         mq.delete();
         merr = 1'b0;
      end else if (merr) begin
         merr = 1'b1;
      end else if (mq.size() == N) begin
         if (ordy) mq.delete();
      end else if (v) begin
         if (int'(d) <= 9) mq.push_back(int'(d));
         else merr = 1'b1;
      end
      #1;
   endtask

   task automatic test_reset();
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      exp_v = pack(16'h0, 3'd0, 1'b0, 1'b1, 1'b0);
      compared++;
      if (obs !== exp_v) begin
         mismatched++;
         $display("FAIL reset_values: got %h expected %h", obs, exp_v);
      end
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_collect();
      logic [3:0] digs [4] = '{4'd1, 4'd9, 4'd0, 4'd5};
      for (int i = 0; i < 4; i++) begin
         step(1'b1, digs[i], 1'b0, 1'b0, 1'b0);
         exp_v = model_view();
         compared++;
         if (obs !== exp_v) begin
            mismatched++;
            $display("FAIL collect_digit%0d: got %h expected %h", i, obs, exp_v);
         end
      end
      exp_v = pack(16'h1905, 3'd4, 1'b1, 1'b0, 1'b0);
      compared++;
      if (obs !== exp_v) begin
         mismatched++;
         $display("FAIL collect_full_word: got %h expected %h", obs, exp_v);
      end
   endtask

   task automatic test_hold_full();
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
         exp_v = pack(16'h1905, 3'd4, 1'b1, 1'b0, 1'b0);
         compared++;
         if (obs !== exp_v) begin
            mismatched++;
            $display("FAIL hold_full_cyc%0d: got %h expected %h", i, obs, exp_v);
         end
      end
      step(1'b1, 4'd7, 1'b0, 1'b1, 1'b0);
      exp_v = pack(16'h0, 3'd0, 1'b0, 1'b1, 1'b0);
      compared++;
      if (obs !== exp_v) begin
         mismatched++;
         $display("FAIL output_transfer: got %h expected %h", obs, exp_v);
      end
      step(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
      exp_v = pack(16'h0007, 3'd1, 1'b0, 1'b1, 1'b0);
      compared++;
      if (obs !== exp_v) begin
         mismatched++;
         $display("FAIL accept_after_transfer: got %h expected %h", obs, exp_v);
      end
      step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_error();
      step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
      exp_v = pack(16'h0003, 3'd1, 1'b0, 1'b0, 1'b1);
      compared++;
      if (obs !== exp_v) begin
         mismatched++;
         $display("FAIL error_entry: got %h expected %h", obs, exp_v);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 4'd5, 1'b0, 1'b1, 1'b0);
         compared++;
         if (obs !== exp_v) begin
            mismatched++;
            $display("FAIL error_sticky%0d: got %h expected %h", i, obs, exp_v);
         end
      end
      step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      exp_v = pack(16'h0, 3'd0, 1'b0, 1'b1, 1'b0);
      compared++;
      if (obs !== exp_v) begin
         mismatched++;
         $display("FAIL error_clear: got %h expected %h", obs, exp_v);
      end
   endtask

   task automatic test_boundary();
      for (int d = 10; d < 16; d++) begin
         step(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
         exp_v = pack(16'h0009, 3'd1, 1'b0, 1'b1, 1'b0);
         compared++;
         if (obs !== exp_v) begin
            mismatched++;
            $display("FAIL accept_nine: got %h expected %h", obs, exp_v);
         end
         step(1'b1, 4'(d), 1'b0, 1'b0, 1'b0);
         exp_v = pack(16'h0009, 3'd1, 1'b0, 1'b0, 1'b1);
         compared++;
         if (obs !== exp_v) begin
            mismatched++;
            $display("FAIL reject_%0d: got %h expected %h", d, obs, exp_v);
         end
         step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      end
      step(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
      exp_v = pack(16'h0090, 3'd2, 1'b0, 1'b1, 1'b0);
      compared++;
      if (obs !== exp_v) begin
         mismatched++;
         $display("FAIL accept_zero: got %h expected %h", obs, exp_v);
      end
      step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_clear_priority();
      step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'd6, 1'b1, 1'b0, 1'b0);
      exp_v = pack(16'h0, 3'd0, 1'b0, 1'b1, 1'b0);
      compared++;
      if (obs !== exp_v) begin
         mismatched++;
         $display("FAIL clear_vs_accept: got %h expected %h", obs, exp_v);
      end
      for (int i = 1; i <= 4; i++) step(1'b1, 4'(2 * i), 1'b0, 1'b0, 1'b0);
      exp_v = pack(16'h2468, 3'd4, 1'b1, 1'b0, 1'b0);
      compared++;
      if (obs !== exp_v) begin
         mismatched++;
         $display("FAIL fill_2468: got %h expected %h", obs, exp_v);
      end
      step(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
      exp_v = pack(16'h0, 3'd0, 1'b0, 1'b1, 1'b0);
      compared++;
      if (obs !== exp_v) begin
         mismatched++;
         $display("FAIL clear_vs_transfer: got %h expected %h", obs, exp_v);
      end
   endtask

   task automatic test_reset_mid();
      step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'd5, 1'b0, 1'b1, 1'b1);
      exp_v = pack(16'h0, 3'd0, 1'b0, 1'b1, 1'b0);
      compared++;
      if (obs !== exp_v) begin
         mismatched++;
         $display("FAIL reset_mid_entry: got %h expected %h", obs, exp_v);
      end
      for (int i = 0; i < 4; i++) step(1'b1, 4'(i + 5), 1'b0, 1'b0, 1'b0);
      exp_v = pack(16'h5678, 3'd4, 1'b1, 1'b0, 1'b0);
      compared++;
      if (obs !== exp_v) begin
         mismatched++;
         $display("FAIL fill_5678: got %h expected %h", obs, exp_v);
      end
      step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
      exp_v = pack(16'h0, 3'd0, 1'b0, 1'b1, 1'b0);
      compared++;
      if (obs !== exp_v) begin
         mismatched++;
         $display("FAIL reset_mid_full: got %h expected %h", obs, exp_v);
      end
      step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      compared++;
      if (out_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL no_emit_after_reset: got out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_random();
      logic       v, clr, ordy, rst;
      logic [3:0] d;
      for (int i = 0; i < 600; i++) begin
         v    = ($urandom_range(0, 3) != 0);
         d    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                            : 4'($urandom_range(0, 9));
         clr  = ($urandom_range(0, 15) == 0);
         ordy = ($urandom_range(0, 1) == 1);
         rst  = ($urandom_range(0, 63) == 0);
         step(v, d, clr, ordy, rst);
         exp_v = model_view();
         compared++;
         if (obs !== exp_v) begin
            mismatched++;
            $display("FAIL random_cyc%0d: got %h expected %h", i, obs, exp_v);
         end
      end
   endtask

   initial begin
      reset     = 1'b1;
      in_digit  = 4'h0;
      in_valid  = 1'b0;
      clear     = 1'b0;
      out_ready = 1'b0;
      merr      = 1'b0;
      test_reset();
      test_collect();
      test_hold_full();
      test_error();
      test_boundary();
      test_clear_priority();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
